instr_lane_router: RTL and testbench

INSTR_LANE_ROUTER -- requirements
Module: instr_lane_router

---
 rtl/instr_lane_router.sv | 120 ++++++++++++
 tb/tb_instr_lane_router.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_lane_router.sv
// Routes app and maintenance instructions round-robin into per-lane instruction FIFOs,
// counts each app sequence and hands it to the dispatcher once its END word arrives.
module instr_lane_router #(
  parameter int          NUM_LANES   = 2,
  parameter int          INSTR_WIDTH = 32,
  parameter logic [3:0]  END_OPCODE  = 4'hF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatcher_ready,
  input  logic                   app_en,
  output logic                   app_ack,
  input  logic [INSTR_WIDTH-1:0] app_instr,
  input  logic                   maint_en,
  output logic                   maint_ack,
  input  logic [INSTR_WIDTH-1:0] maint_instr,
  output logic [NUM_LANES-1:0]   lane_wr_en,
  output logic [INSTR_WIDTH-1:0] lane_wr_data,
  input  logic [NUM_LANES-1:0]   lane_full,
  output logic                   process_iseq,
  output logic [INSTR_WIDTH-1:0] issued_instr,
  output logic                   is_issued_app,
  output logic                   is_issued_mnt,
  output logic [15:0]            seq_len
);

  localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {IDLE, APP, ISSUE, WAIT} state_t;

  state_t                 state_reg, state_next;
  logic [PTR_W-1:0]       lane_ptr_reg;
  logic [15:0]            cnt_reg;
  logic [15:0]            seq_len_reg;
  logic [INSTR_WIDTH-1:0] issued_instr_reg;
  logic                   is_issued_app_reg, is_issued_mnt_reg;

  logic is_end, app_xfer, app_wr, seq_end;

  assign is_end   = (app_instr[INSTR_WIDTH-1 -: 4] == END_OPCODE);
  assign app_xfer = app_en & app_ack;
  assign app_wr   = app_xfer & ~is_end;
  // An END seen in IDLE is an empty sequence: acked but never closes anything.
  assign seq_end  = app_xfer & is_end & (state_reg == APP);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (maint_ack) state_next = ISSUE;
               else if (app_wr) state_next = APP;
      APP:     if (seq_end) state_next = ISSUE;
      ISSUE:   if (!dispatcher_ready) state_next = WAIT;
      WAIT:    if (dispatcher_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Maintenance wins in IDLE; app traffic only stalls on the lane it would write next.
  always_comb begin
    app_ack      = 1'b0;
    maint_ack    = 1'b0;
    process_iseq = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          maint_ack = maint_en & dispatcher_ready;
          app_ack   = ~(maint_en & dispatcher_ready) & ~lane_full[lane_ptr_reg];
        end
        APP:     app_ack = ~lane_full[lane_ptr_reg];
        ISSUE:   process_iseq = 1'b1;
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_wr_en[gi] = (app_wr && (lane_ptr_reg == PTR_W'(gi))) || ((gi == 0) && maint_ack);
    end
  endgenerate

  assign lane_wr_data = maint_ack ? maint_instr : app_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_ptr_reg      <= '0;
      cnt_reg           <= '0;
      seq_len_reg       <= '0;
      issued_instr_reg  <= '0;
      is_issued_app_reg <= 1'b0;
      is_issued_mnt_reg <= 1'b0;
    end else begin
      is_issued_app_reg <= app_wr;
      is_issued_mnt_reg <= maint_ack;
      if (app_wr || maint_ack) issued_instr_reg <= lane_wr_data;
      if (app_wr) begin
        if (lane_ptr_reg == PTR_W'(NUM_LANES - 1)) lane_ptr_reg <= '0;
        else                                       lane_ptr_reg <= lane_ptr_reg + PTR_W'(1);
        if (cnt_reg != 16'hFFFF) cnt_reg <= cnt_reg + 16'd1;
      end
      if (seq_end) begin
        seq_len_reg  <= cnt_reg;
        cnt_reg      <= '0;
        lane_ptr_reg <= '0;
      end
    end
  end

  assign issued_instr  = issued_instr_reg;
  assign is_issued_app = is_issued_app_reg;
  assign is_issued_mnt = is_issued_mnt_reg;
  assign seq_len       = seq_len_reg;

endmodule

// File: tb/tb_instr_lane_router.sv
// Directed bench: a 2-lane and a 4-lane router share stimulus; each scenario
// checks against hand-computed lane strobes, acks and sequence lengths.
module tb_instr_lane_router;

  localparam logic [31:0] I_A   = 32'h1000_00AA;
  localparam logic [31:0] I_B   = 32'h2000_00BB;
  localparam logic [31:0] I_C   = 32'h3000_00CC;
  localparam logic [31:0] I_D   = 32'h4000_00DD;
  localparam logic [31:0] I_E   = 32'h6000_00EE;
  localparam logic [31:0] I_M   = 32'h5000_0055;
  localparam logic [31:0] I_END = 32'hF000_0000;

  logic        clk, rst, dispatcher_ready;
  logic        app_en, maint_en;
  logic [31:0] app_instr, maint_instr;
  logic [1:0]  lane_full_2;
  logic [3:0]  lane_full_4;

  logic        app_ack_2, maint_ack_2, process_iseq_2, is_app_2, is_mnt_2;
  logic [1:0]  lane_wr_en_2;
  logic [31:0] lane_wr_data_2, issued_2;
  logic [15:0] seq_len_2;

  logic        app_ack_4, maint_ack_4, process_iseq_4, is_app_4, is_mnt_4;
  logic [3:0]  lane_wr_en_4;
  logic [31:0] lane_wr_data_4, issued_4;
  logic [15:0] seq_len_4;

  int n_cmp = 0;
  int n_err = 0;

  instr_lane_router #(.NUM_LANES(2), .INSTR_WIDTH(32), .END_OPCODE(4'hF)) u_dut_2 (
    .clk(clk), .rst(rst), .dispatcher_ready(dispatcher_ready),
    .app_en(app_en), .app_ack(app_ack_2), .app_instr(app_instr),
    .maint_en(maint_en), .maint_ack(maint_ack_2), .maint_instr(maint_instr),
    .lane_wr_en(lane_wr_en_2), .lane_wr_data(lane_wr_data_2), .lane_full(lane_full_2),
    .process_iseq(process_iseq_2), .issued_instr(issued_2),
    .is_issued_app(is_app_2), .is_issued_mnt(is_mnt_2), .seq_len(seq_len_2)
  );

  instr_lane_router #(.NUM_LANES(4), .INSTR_WIDTH(32), .END_OPCODE(4'hF)) u_dut_4 (
    .clk(clk), .rst(rst), .dispatcher_ready(dispatcher_ready),
    .app_en(app_en), .app_ack(app_ack_4), .app_instr(app_instr),
    .maint_en(maint_en), .maint_ack(maint_ack_4), .maint_instr(maint_instr),
    .lane_wr_en(lane_wr_en_4), .lane_wr_data(lane_wr_data_4), .lane_full(lane_full_4),
    .process_iseq(process_iseq_4), .issued_instr(issued_4),
    .is_issued_app(is_app_4), .is_issued_mnt(is_mnt_4), .seq_len(seq_len_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // One app transfer attempt: combinational checks mid-cycle, registered checks after the edge.
  task automatic app_txn(input string name, input logic [31:0] instr, input logic exp_ack,
                         input logic [1:0] exp_wr2, input logic [3:0] exp_wr4, input bit use2);
    app_en    = 1'b1;
    app_instr = instr;
    mid();
    chk({name, "_ack4"}, app_ack_4, exp_ack);
    chk({name, "_wr4"}, lane_wr_en_4, exp_wr4);
    chk({name, "_mack4"}, maint_ack_4, 1'b0);
    if (exp_wr4 != 4'b0) chk({name, "_data4"}, lane_wr_data_4, instr);
    if (use2) begin
      chk({name, "_ack2"}, app_ack_2, exp_ack);
      chk({name, "_wr2"}, lane_wr_en_2, exp_wr2);
    end
    tick();
    app_en = 1'b0;
    $display("txn %s instr=%h ack4=%0b wr4=%b", name, instr, exp_ack, exp_wr4);
    if (exp_wr4 != 4'b0) begin
      chk({name, "_issued4"}, issued_4, instr);
      chk({name, "_isapp4"}, is_app_4, 1'b1);
      chk({name, "_ismnt4"}, is_mnt_4, 1'b0);
    end
  endtask

  task automatic dispatch_cycle();
    dispatcher_ready = 1'b0;
    tick();
    dispatcher_ready = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; dispatcher_ready = 1'b1;
    app_en = 1'b1; app_instr = I_A; maint_en = 1'b1; maint_instr = I_M;
    lane_full_2 = '0; lane_full_4 = '0;

    // Reset: acks and strobes forced low even with requests pending
    tick();
    mid();
    chk("rst_app_ack4", app_ack_4, 1'b0);
    chk("rst_maint_ack4", maint_ack_4, 1'b0);
    chk("rst_wr4", lane_wr_en_4, 4'b0);
    chk("rst_wr2", lane_wr_en_2, 2'b0);
    tick();
    rst = 1'b0; app_en = 1'b0; maint_en = 1'b0;
    chk("rst_seq_len4", seq_len_4, 16'd0);
    chk("rst_issued4", issued_4, 32'd0);
    chk("rst_isapp4", is_app_4, 1'b0);
    chk("rst_ismnt4", is_mnt_4, 1'b0);
    chk("rst_piseq4", process_iseq_4, 1'b0);

    // A,B,C,END on 2 lanes: 0,1,0; maintenance during APP ignored
    app_txn("A", I_A, 1'b1, 2'b01, 4'b0001, 1'b1);
    maint_en = 1'b1;
    app_txn("B", I_B, 1'b1, 2'b10, 4'b0010, 1'b1);
    maint_en = 1'b0;
    app_txn("C", I_C, 1'b1, 2'b01, 4'b0100, 1'b1);
    app_txn("END", I_END, 1'b1, 2'b00, 4'b0000, 1'b1);
    chk("seq_piseq2", process_iseq_2, 1'b1);
    chk("seq_len2", seq_len_2, 16'd3);
    chk("seq_len4", seq_len_4, 16'd3);
    chk("seq_isapp_drop2", is_app_2, 1'b0);
    app_en = 1'b1; app_instr = I_A;
    mid();
    chk("issue_ack2", app_ack_2, 1'b0);
    chk("issue_wr2", lane_wr_en_2, 2'b0);
    tick();
    dispatcher_ready = 1'b0;
    mid();
    chk("issue_hold_piseq2", process_iseq_2, 1'b1);
    tick();
    app_en = 1'b0; maint_en = 1'b1;
    mid();
    chk("wait_piseq2", process_iseq_2, 1'b0);
    chk("wait_mack2", maint_ack_2, 1'b0);
    dispatcher_ready = 1'b1;
    tick();
    maint_en = 1'b0;
    chk("idle_piseq2", process_iseq_2, 1'b0);

    // 4 lanes: stall on full lane 2 for 5 cycles, then resume at lane 2, 3, wrap to 0
    app_txn("A4", I_A, 1'b1, 2'b01, 4'b0001, 1'b0);
    app_txn("B4", I_B, 1'b1, 2'b10, 4'b0010, 1'b0);
    lane_full_4 = 4'b0100;
    app_en = 1'b1; app_instr = I_C;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("stall_ack4", app_ack_4, 1'b0);
      chk("stall_wr4", lane_wr_en_4, 4'b0);
      tick();
    end
    lane_full_4 = 4'b1011;
    app_txn("C4", I_C, 1'b1, 2'b00, 4'b0100, 1'b0);
    lane_full_4 = 4'b0000;
    app_txn("D4", I_D, 1'b1, 2'b00, 4'b1000, 1'b0);
    app_txn("E4", I_E, 1'b1, 2'b00, 4'b0001, 1'b0);
    app_txn("END4", I_END, 1'b1, 2'b00, 4'b0000, 1'b0);
    chk("stall_seq_len4", seq_len_4, 16'd5);
    chk("stall_piseq4", process_iseq_4, 1'b1);
    dispatch_cycle();

    // Empty sequence: END in IDLE acked and dropped
    app_txn("END_IDLE", I_END, 1'b1, 2'b00, 4'b0000, 1'b1);
    chk("empty_piseq4", process_iseq_4, 1'b0);
    chk("empty_seq_len4", seq_len_4, 16'd5);
    chk("empty_isapp4", is_app_4, 1'b0);

    // Maintenance beats app in IDLE
    maint_en = 1'b1; app_en = 1'b1; app_instr = I_A; maint_instr = I_M;
    mid();
    chk("mnt_mack4", maint_ack_4, 1'b1);
    chk("mnt_ack4", app_ack_4, 1'b0);
    chk("mnt_wr4", lane_wr_en_4, 4'b0001);
    chk("mnt_data4", lane_wr_data_4, I_M);
    chk("mnt_wr2", lane_wr_en_2, 2'b01);
    tick();
    maint_en = 1'b0;
    $display("txn MAINT instr=%h", I_M);
    chk("mnt_issued4", issued_4, I_M);
    chk("mnt_ismnt4", is_mnt_4, 1'b1);
    chk("mnt_isapp4", is_app_4, 1'b0);
    chk("mnt_piseq4", process_iseq_4, 1'b1);
    mid();
    chk("mnt_issue_ack4", app_ack_4, 1'b0);
    tick();
    app_en = 1'b0;
    chk("mnt_pulse4", is_mnt_4, 1'b0);
    dispatch_cycle();

    // Reset mid-sequence: restart at lane 0, count only post-reset words
    app_txn("RA", I_A, 1'b1, 2'b01, 4'b0001, 1'b1);
    app_txn("RB", I_B, 1'b1, 2'b10, 4'b0010, 1'b1);
    rst = 1'b1; app_en = 1'b1; app_instr = I_C;
    mid();
    chk("rstmid_ack4", app_ack_4, 1'b0);
    chk("rstmid_wr4", lane_wr_en_4, 4'b0);
    chk("rstmid_ack2", app_ack_2, 1'b0);
    tick();
    rst = 1'b0; app_en = 1'b0;
    chk("rstmid_isapp4", is_app_4, 1'b0);
    app_txn("RC", I_C, 1'b1, 2'b01, 4'b0001, 1'b1);
    app_txn("RD", I_D, 1'b1, 2'b10, 4'b0010, 1'b1);
    app_txn("REND", I_END, 1'b1, 2'b00, 4'b0000, 1'b1);
    chk("rstmid_seq_len4", seq_len_4, 16'd2);
    chk("rstmid_seq_len2", seq_len_2, 16'd2);
    // Reset while in ISSUE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstiss_piseq4", process_iseq_4, 1'b0);
    chk("rstiss_seq_len4", seq_len_4, 16'd0);

    // Saturation: 70000 app words then END
    app_en = 1'b1; app_instr = 32'h1000_0001;
    for (int i = 0; i < 70000; i++) tick();
    app_en = 1'b0;
    $display("txn BULK count=70000");
    app_txn("SAT_END", I_END, 1'b1, 2'b00, 4'b0000, 1'b1);
    chk("sat_seq_len2", seq_len_2, 16'hFFFF);
    chk("sat_seq_len4", seq_len_4, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
